// File: rtl/rob_pkg.sv
// rob_pkg: ROB-wide sizing constants and the shared ROB index type.
package rob_pkg;
  localparam int DEF_ROB_SIZE = 128;
  localparam int ROB_IDX_W = $clog2(DEF_ROB_SIZE);
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_BUF_DEPTH = 2;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
endpackage

// File: rtl/finish_fifo.sv
// finish_fifo: small per-port completion FIFO with a head-of-queue output.
module finish_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push & ~clr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/rob_finish_arb.sv
// rob_finish_arb: round-robin arbiter funnelling unit completions into the ROB finish port.
module rob_finish_arb
  import rob_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ROB_SIZE = DEF_ROB_SIZE,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  localparam int IDXW = $clog2(ROB_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IDXW-1:0] req_rob_entry,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    flush,
  output logic                    uop_finish,
  output logic [IDXW-1:0]         uop_finish_rob_entry,
  output logic                    idle
);
  localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] push, pop, full, empty, cand;
  logic [IDXW-1:0] head [NUM_REQ];
  logic [$clog2(BUF_DEPTH):0] count [NUM_REQ];
  logic [RRW-1:0] rr, win, nxt;
  logic found;
  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_port
      assign req_ready[i] = ~full[i];
      assign push[i] = req_valid[i] & req_ready[i] & ~flush;
      assign pop[i] = found & (win == RRW'(i)) & ~flush;
      assign cand[i] = count[i] != '0;
      finish_fifo #(.DEPTH(BUF_DEPTH), .W(IDXW)) u_fifo (
        .clk(clk), .rst(rst), .push(push[i]), .pop(pop[i]), .clr(flush),
        .din(req_rob_entry[i*IDXW +: IDXW]), .dout(head[i]), .count(count[i]),
        .full(full[i]), .empty(empty[i])
      );
    end
  endgenerate
  // descending scan so the candidate closest to rr is the last (winning) assignment
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (cand[(int'(rr) + k) % NUM_REQ]) begin
        win = RRW'((int'(rr) + k) % NUM_REQ);
        found = 1'b1;
      end
    nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr <= '0;
      uop_finish <= 1'b0;
      uop_finish_rob_entry <= '0;
    end else if (flush) begin
      rr <= '0;
      uop_finish <= 1'b0;
    end else begin
      uop_finish <= found;
      if (found) begin
        uop_finish_rob_entry <= head[win];
        rr <= nxt;
      end
    end
  assign idle = &empty & ~uop_finish;
endmodule

// File: tb/tb_rob_finish_arb.sv
// tb_rob_finish_arb: directed checks of acceptance, round-robin order, backpressure and flush.
module tb_rob_finish_arb;
  import rob_pkg::*;
  localparam int N = 4;
  localparam int W = ROB_IDX_W;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_rob_entry = '0;
  logic [N-1:0] req_ready;
  logic flush = 1'b0;
  logic uop_finish;
  logic [W-1:0] uop_finish_rob_entry;
  logic idle;
  int checks = 0;
  int errors = 0;
  rob_idx_t log_q[$];

  rob_finish_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rob_entry(req_rob_entry),
    .req_ready(req_ready), .flush(flush), .uop_finish(uop_finish),
    .uop_finish_rob_entry(uop_finish_rob_entry), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rst && uop_finish) log_q.push_back(uop_finish_rob_entry);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input int idx);
    req_valid[p] = 1'b1;
    req_rob_entry[p*W +: W] = W'(idx);
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = 1'b0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    step();
    log_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if (req_ready !== 4'b1111 || uop_finish !== 1'b0 || uop_finish_rob_entry !== '0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: ready=%b fin=%b entry=%0d idle=%b want 1111 0 0 1", req_ready, uop_finish, uop_finish_rob_entry, idle);
    end
    #3 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (req_ready !== 4'b1111 || uop_finish !== 1'b0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: ready=%b fin=%b idle=%b want 1111 0 1", c, req_ready, uop_finish, idle);
      end
    end
  endtask

  task automatic test_single();
    set_req(2, 37);
    step();
    req_valid = '0;
    checks++;
    if (uop_finish !== 1'b0) begin
      errors++;
      $display("FAIL single_early: fin=%b want 0", uop_finish);
    end
    step();
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd37) begin
      errors++;
      $display("FAIL single_grant: fin=%b entry=%0d want 1 37", uop_finish, uop_finish_rob_entry);
    end
    step();
    checks++;
    if (uop_finish !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL single_after: fin=%b idle=%b want 0 1", uop_finish, idle);
    end
  endtask

  task automatic test_all_ports();
    int exp_q[$] = '{11, 12, 13, 20, 21, 22, 23};
    do_reset();
    for (int p = 0; p < N; p++) set_req(p, 10 + p);
    step();
    checks++;
    if (req_ready !== 4'b1111 || uop_finish !== 1'b0) begin
      errors++;
      $display("FAIL all_first: ready=%b fin=%b want 1111 0", req_ready, uop_finish);
    end
    for (int p = 0; p < N; p++) set_req(p, 20 + p);
    step();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0001 || uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd10) begin
      errors++;
      $display("FAIL all_full: ready=%b fin=%b entry=%0d want 0001 1 10", req_ready, uop_finish, uop_finish_rob_entry);
    end
    foreach (exp_q[j]) begin
      step();
      checks++;
      if (uop_finish !== 1'b1 || uop_finish_rob_entry !== W'(exp_q[j])) begin
        errors++;
        $display("FAIL all_order%0d: fin=%b entry=%0d want 1 %0d", j, uop_finish, uop_finish_rob_entry, exp_q[j]);
      end
    end
    step();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL all_idle: idle=%b want 1", idle);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      set_req(1, 50 + n);
      guard = 0;
      while (!req_ready[1] && guard < 20) begin
        step();
        guard++;
      end
      checks++;
      if (guard >= 20) begin
        errors++;
        $display("FAIL bp_ready_timeout req%0d: ready=%b want port1 ready", n, req_ready);
      end
      step();
    end
    req_valid = '0;
    repeat (5) step();
    checks++;
    if (log_q.size() !== 3) begin
      errors++;
      $display("FAIL bp_count: got %0d grants want 3", log_q.size());
    end
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (n >= log_q.size() || log_q[n] !== W'(50 + n)) begin
        errors++;
        $display("FAIL bp_order%0d: got %0d want %0d", n, (n < log_q.size()) ? int'(log_q[n]) : -1, 50 + n);
      end
    end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    set_req(3, 33);
    step();
    req_valid = '0;
    set_req(0, 40);
    set_req(3, 34);
    step();
    req_valid = '0;
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd33) begin
      errors++;
      $display("FAIL wrap_first: fin=%b entry=%0d want 1 33", uop_finish, uop_finish_rob_entry);
    end
    step();
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd40) begin
      errors++;
      $display("FAIL wrap_port0: fin=%b entry=%0d want 1 40", uop_finish, uop_finish_rob_entry);
    end
    step();
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd34) begin
      errors++;
      $display("FAIL wrap_port3: fin=%b entry=%0d want 1 34", uop_finish, uop_finish_rob_entry);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int p = 0; p < N; p++) set_req(p, 60 + p);
    step();
    req_valid = '0;
    set_req(1, 65);
    set_req(2, 66);
    step();
    req_valid = '0;
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd60 || req_ready !== 4'b1001) begin
      errors++;
      $display("FAIL flush_setup: fin=%b entry=%0d ready=%b want 1 60 1001", uop_finish, uop_finish_rob_entry, req_ready);
    end
    set_req(0, 67);
    flush = 1'b1;
    step();
    flush = 1'b0;
    req_valid = '0;
    checks++;
    if (uop_finish !== 1'b0 || idle !== 1'b1 || req_ready !== 4'b1111) begin
      errors++;
      $display("FAIL flush_clear: fin=%b idle=%b ready=%b want 0 1 1111", uop_finish, idle, req_ready);
    end
    log_q.delete();
    repeat (5) step();
    checks++;
    if (log_q.size() !== 0) begin
      errors++;
      $display("FAIL flush_leak: got %0d grants want 0", log_q.size());
    end
    set_req(0, 70);
    set_req(3, 71);
    step();
    req_valid = '0;
    step();
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd70) begin
      errors++;
      $display("FAIL flush_rr0: fin=%b entry=%0d want 1 70", uop_finish, uop_finish_rob_entry);
    end
    step();
    checks++;
    if (uop_finish !== 1'b1 || uop_finish_rob_entry !== 7'd71) begin
      errors++;
      $display("FAIL flush_rr3: fin=%b entry=%0d want 1 71", uop_finish, uop_finish_rob_entry);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 80);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (uop_finish !== 1'b0 || req_ready !== 4'b1111 || idle !== 1'b1 || uop_finish_rob_entry !== '0) begin
      errors++;
      $display("FAIL async_reset: fin=%b ready=%b idle=%b entry=%0d want 0 1111 1 0", uop_finish, req_ready, idle, uop_finish_rob_entry);
    end
    req_valid = '0;
    #2 rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_ports();
    test_backpressure();
    test_rr_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
